// File: rtl/ctech_lib_en_ctl_pkg.sv
// ctech_lib_en_ctl_pkg: shared state encoding and counter sizing for the gated-enable controller
package ctech_lib_en_ctl_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        ON   = 2'd2,
        HOLD = 2'd3
    } en_state_e;

    localparam int WAKE_CYC_MAX = 15;
    localparam int WAKE_W = $clog2(WAKE_CYC_MAX + 1);

endpackage

// File: rtl/ctech_lib_and.sv
// ctech_lib_and: two-input AND library cell
module ctech_lib_and (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a & b;

endmodule

// File: rtl/ctech_lib_en_ctl_cnt.sv
// ctech_lib_en_ctl_cnt: loadable up/down counter that saturates at both ends
module ctech_lib_en_ctl_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt
);

    // load wins over counting; counting stops at all-ones going up and zero going down
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (inc && cnt != '1) cnt <= cnt + 1'b1;
        else if (dec && cnt != '0) cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/ctech_lib_and_en_ctl.sv
// ctech_lib_and_en_ctl: sequences a shared AND-gated enable domain with wake delay and idle hysteresis
module ctech_lib_and_en_ctl #(
    parameter int NUM_REQ  = 4,
    parameter int WAKE_CYC = 2,
    parameter int IDLE_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    input  logic [NUM_REQ-1:0] vld_i,
    output logic [NUM_REQ-1:0] vld_o,
    input  logic [IDLE_W-1:0]  idle_limit,
    input  logic               force_on,
    output logic               gate_en,
    output logic               busy
);

    import ctech_lib_en_ctl_pkg::*;

    en_state_e          state, next_state;
    logic [WAKE_W-1:0]  wake_cnt;
    logic [IDLE_W-1:0]  idle_cnt;
    logic               any_req;

    assign any_req = |req || force_on;

    // next-state: a started wake always completes; a request in HOLD beats the idle timeout
    always_comb begin
        next_state = state;
        unique case (state)
            OFF:  next_state = any_req ? WAKE : OFF;
            WAKE: next_state = wake_cnt != '0 ? WAKE : (any_req ? ON : HOLD);
            ON:   next_state = any_req ? ON : HOLD;
            HOLD: next_state = any_req ? ON : (idle_cnt >= idle_limit ? OFF : HOLD);
        endcase
    end

    // gate_en comes straight from a flop so the AND cells never see a glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= OFF;
            gate_en <= 1'b0;
        end else begin
            state   <= next_state;
            gate_en <= next_state != OFF;
        end
    end

    ctech_lib_en_ctl_cnt #(.W(WAKE_W)) u_wake_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state == OFF && any_req),
        .load_val (WAKE_W'(WAKE_CYC - 1)),
        .inc      (1'b0),
        .dec      (state == WAKE),
        .cnt      (wake_cnt)
    );

    ctech_lib_en_ctl_cnt #(.W(IDLE_W)) u_idle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (next_state == HOLD && state != HOLD),
        .load_val ('0),
        .inc      (state == HOLD),
        .dec      (1'b0),
        .cnt      (idle_cnt)
    );

    assign ack  = req & {NUM_REQ{state == ON || state == HOLD}};
    assign busy = state != OFF;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_and
        ctech_lib_and u_and (
            .a (vld_i[i]),
            .b (gate_en),
            .y (vld_o[i])
        );
    end

endmodule

// File: tb/tb_ctech_lib_and_en_ctl.sv
// tb_ctech_lib_and_en_ctl: scoreboard bench with a cycle model plus directed latency checks
module tb_ctech_lib_and_en_ctl;

    localparam int N = 4;
    localparam int WAKE_CYC = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req, ack, vld_i, vld_o;
    logic [7:0]   idle_limit;
    logic         force_on, gate_en, busy;

    int checks = 0;
    int errors = 0;
    int m_st = 0;
    int m_wk = 0;
    int m_id = 0;
    logic [9:0] sb[$];

    ctech_lib_and_en_ctl #(.NUM_REQ(N), .WAKE_CYC(WAKE_CYC), .IDLE_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ack        (ack),
        .vld_i      (vld_i),
        .vld_o      (vld_o),
        .idle_limit (idle_limit),
        .force_on   (force_on),
        .gate_en    (gate_en),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        bit any;
        logic [9:0] e;
        any = (|req) || force_on;
        if (rst) begin
            m_st = 0; m_wk = 0; m_id = 0;
        end else begin
            case (m_st)
                0: if (any) begin m_st = 1; m_wk = WAKE_CYC - 1; end
                1: if (m_wk == 0) begin m_st = any ? 2 : 3; m_id = 0; end else m_wk--;
                2: if (!any) begin m_st = 3; m_id = 0; end
                default: if (any) m_st = 2; else if (m_id >= int'(idle_limit)) m_st = 0; else if (m_id < 255) m_id++;
            endcase
        end
        e = {m_st != 0, m_st != 0, req & {N{m_st >= 2}}, vld_i & {N{m_st != 0}}};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin
            e = sb.pop_front();
            chk("gate_en", gate_en, e[9]);
            chk("busy", busy, e[8]);
            chk("ack", ack, e[7:4]);
            chk("vld_o", vld_o, e[3:0]);
        end
    endtask

    task automatic measure_hold(input string tag, input int exp);
        int n = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (!gate_en) break;
            n++;
        end
        chk(tag, n, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [N-1:0] ack_seen;
        rst = 1'b1; req = 4'b1111; force_on = 1'b0; vld_i = 4'b0000; idle_limit = 8'd5;
        #1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_gate", gate_en, 0);
            chk("rst_ack", ack, 0);
            chk("rst_busy", busy, 0);
        end
        rst = 1'b0;
        step(); chk("t1_gate_c1", gate_en, 1);
        step(); chk("t1_ack_c2", ack, 4'b0000);
        step(); chk("t1_ack_c3", ack, 4'b1111);
        req = 4'b0000; idle_limit = 8'd0;
        measure_hold("t1_hold_lim0", 1);
        req = 4'b0100; vld_i = 4'b0100;
        #1 chk("t2_vld_t10", vld_o, 4'b0000);
        step(); chk("t2_vld_t11", vld_o, 4'b0100);
        step(); chk("t2_ack_t12", ack, 4'b0000);
        step(); chk("t2_ack_t13", ack, 4'b0100);
        idle_limit = 8'd5; req = 4'b0000;
        measure_hold("t3_hold_lim5", 6);
        req = 4'b0001;
        step(); step(); step();
        req = 4'b0000; idle_limit = 8'd0;
        measure_hold("t3_hold_lim0", 1);
        req = 4'b0001; idle_limit = 8'd5;
        step(); step(); step();
        req = 4'b0000;
        step(); step(); step();
        req = 4'b0010;
        #1 chk("t4_ack_same", ack, 4'b0010);
        step(); chk("t4_gate", gate_en, 1); chk("t4_busy", busy, 1);
        idle_limit = 8'd2; req = 4'b0000;
        step(); step(); step();
        req = 4'b1000;
        step(); chk("t5_coll_gate", gate_en, 1); chk("t5_coll_ack", ack, 4'b1000);
        req = 4'b0000; idle_limit = 8'd0;
        measure_hold("t5_off", 1);
        req = 4'b0001;
        #1 ack_seen = ack;
        step();
        req = 4'b0000;
        cnt = 1;
        for (int k = 0; k < 6; k++) begin
            ack_seen |= ack;
            step();
            if (gate_en) cnt++;
        end
        chk("t5_pulse_ack", ack_seen, 0);
        chk("t5_pulse_len", cnt, WAKE_CYC + 1);
        req = 4'b0001;
        step();
        rst = 1'b1;
        step(); chk("t6_rst_gate", gate_en, 0); chk("t6_rst_busy", busy, 0);
        rst = 1'b0; req = 4'b0000;
        step(); chk("t6_stay_off", gate_en, 0);
        force_on = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (gate_en) cnt++;
        end
        chk("t6_force_len", cnt, 20);
        force_on = 1'b0; idle_limit = 8'd3;
        measure_hold("t6_force_drop", 4);
        for (int k = 0; k < 300; k++) begin
            rst = ($urandom_range(0, 40) == 0);
            req = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            force_on = ($urandom_range(0, 9) == 0);
            vld_i = N'($urandom);
            if ($urandom_range(0, 7) == 0) idle_limit = 8'($urandom_range(0, 6));
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
